// File: rtl/pwm_fade_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_multi
// Purpose  : Multi-channel LED activity indicator. A trigger on a channel
//            jumps it to full brightness, optionally holds there, then fades
//            to off through PWM. In breathe mode the channel ramps down and
//            up continuously. Steady-on and forced-off modes override the
//            fade engine.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            trigger - per-channel event strobe, level-sampled every cycle
//            mode    - 2 bits per channel: 00 one-shot, 01 breathe,
//                      10 steady on, 11 forced off
//            drive   - registered PWM output per channel
//            busy    - registered, high while the channel FSM is not IDLE
// Options  : define PWM_FADE_GAMMA_EN to compare the PWM counter against a
//            squared (gamma) level; this adds one pipeline stage to drive.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fade_multi #(
    parameter int CHANNELS    = 4,
    parameter int LEVEL_BITS  = 8,
    parameter int FADE_BITS   = 27,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   trigger,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   drive,
    output logic [CHANNELS-1:0]   busy
);

    localparam logic [1:0] c_MODE_FADE    = 2'b00;
    localparam logic [1:0] c_MODE_BREATHE = 2'b01;
    localparam logic [1:0] c_MODE_ON      = 2'b10;
    localparam logic [1:0] c_MODE_OFF     = 2'b11;

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD =
        c_HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    localparam logic [FADE_BITS-1:0] c_FADE_MAX    = {FADE_BITS{1'b1}};
    localparam logic [FADE_BITS-1:0] c_FADE_MAX_M1 = {{(FADE_BITS-1){1'b1}}, 1'b0};
    localparam logic [FADE_BITS-1:0] c_FADE_ONE    = FADE_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FALL = 2'd2,
        ST_RISE = 2'd3
    } state_t;

    // Shared free-running PWM counter; wraps naturally.
    logic [LEVEL_BITS-1:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_t                r_state;
        logic [FADE_BITS-1:0]  r_fade;
        logic [c_HOLD_W-1:0]   r_hold;
        logic                  r_busy;
        logic                  r_drive;
        logic [1:0]            w_mode;
        logic                  w_forced;
        logic [LEVEL_BITS-1:0] w_level;

        assign w_mode   = mode[2*ch +: 2];
        // Modes 10 and 11 both park the fade engine in IDLE.
        assign w_forced = w_mode[1];
        assign w_level  = r_fade[FADE_BITS-1 -: LEVEL_BITS];
        assign busy[ch]  = r_busy;
        assign drive[ch] = r_drive;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_fade  <= '0;
                r_hold  <= '0;
                r_busy  <= 1'b0;
            end else if (w_forced) begin
                r_state <= ST_IDLE;
                r_fade  <= '0;
                r_hold  <= '0;
                r_busy  <= 1'b0;
            end else if (trigger[ch]) begin
                // Restart from any state; a held trigger pins full brightness.
                r_fade <= c_FADE_MAX;
                r_hold <= c_HOLD_LOAD;
                r_busy <= 1'b1;
                if (HOLD_CYCLES > 0) begin
                    r_state <= ST_HOLD;
                end else begin
                    r_state <= ST_FALL;
                end
            end else begin
                r_busy <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        r_fade <= '0;
                        r_busy <= 1'b0;
                    end
                    ST_HOLD: begin
                        if (r_hold == '0) begin
                            r_state <= ST_FALL;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    ST_FALL: begin
                        // Also catches a count of 0 left by a RISE abort.
                        if (r_fade <= c_FADE_ONE) begin
                            r_fade <= '0;
                            if (w_mode == c_MODE_BREATHE) begin
                                r_state <= ST_RISE;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_fade <= r_fade - 1'b1;
                        end
                    end
                    ST_RISE: begin
                        if (w_mode != c_MODE_BREATHE) begin
                            // Leaving breathe: fall from wherever the ramp is.
                            r_state <= ST_FALL;
                        end else if (r_fade >= c_FADE_MAX_M1) begin
                            r_fade  <= c_FADE_MAX;
                            r_state <= ST_FALL;
                        end else begin
                            r_fade <= r_fade + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_fade  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

`ifdef PWM_FADE_GAMMA_EN
        logic [LEVEL_BITS-1:0] w_gamma;
        logic [LEVEL_BITS-1:0] r_gamma;
        logic                  r_full;
        logic                  r_zero;

        assign w_gamma = LEVEL_BITS'(({{LEVEL_BITS{1'b0}}, w_level} *
                                      {{LEVEL_BITS{1'b0}}, w_level}) >> LEVEL_BITS);

        // Full/zero decisions use the raw level so the extremes stay exact.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_gamma <= '0;
                r_full  <= 1'b0;
                r_zero  <= 1'b1;
                r_drive <= 1'b0;
            end else begin
                r_gamma <= w_gamma;
                r_full  <= (w_mode == c_MODE_ON) || (!w_forced && (&w_level));
                r_zero  <= (w_mode == c_MODE_OFF) || (!w_forced && (w_level == '0));
                if (r_full) begin
                    r_drive <= 1'b1;
                end else if (r_zero) begin
                    r_drive <= 1'b0;
                end else begin
                    r_drive <= (r_pwm_cnt < r_gamma);
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_drive <= 1'b0;
            end else if (w_mode == c_MODE_ON) begin
                r_drive <= 1'b1;
            end else if (w_mode == c_MODE_OFF) begin
                r_drive <= 1'b0;
            end else if (&w_level) begin
                r_drive <= 1'b1;
            end else if (w_level == '0) begin
                r_drive <= 1'b0;
            end else begin
                r_drive <= (r_pwm_cnt < w_level);
            end
        end
`endif
    end

endmodule
`default_nettype wire
